spi_frame_scheduler: RTL

- Shares the byte-wide SPI master (mode-0 shifter with transmit/finish/reset handshake) between NUM_REQ requesters.
- Sequences each granted request as a multi-byte frame, MSB byte first. Select stays asserted across all bytes of a frame.
- Sits between the Doppler front-end configuration logic (DAC gain, PLL, ADC setup writers) and the single SPI master instance.

---
 rtl/spi_sched_pkg.sv | 31 +++
 rtl/spi_frame_scheduler_if.sv | 32 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/spi_frame_scheduler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI frame scheduler: FSM encoding, frame sizing and length rules.
package spi_sched_pkg;

   // Default frame capacity in bytes; the top-level MAX_BYTES parameter starts from this.
   localparam int unsigned DEFAULT_MAX_BYTES = 4;
   // Width of a per-requester length field (byte count minus one).
   localparam int unsigned LEN_W = 2;
   // Width of the byte index into the shadow frame.
   localparam int unsigned IDX_W = 2;
   // Width of the inter-frame gap counter (GAP_CYCLES up to 15).
   localparam int unsigned GAP_W = 4;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSend,
      StRearm,
      StDone,
      StGap
   } sched_state_e;

   // Clamp a requested length (count minus one) to the last byte the frame can hold.
   function automatic logic [IDX_W-1:0] sat_len(input logic [LEN_W-1:0] len,
                                                input int unsigned  max_bytes);
      if (32'(len) > max_bytes - 32'd1) begin
         return IDX_W'(max_bytes - 32'd1);
      end
      return len;
   endfunction

endpackage

// File: rtl/spi_frame_scheduler_if.sv
// Requester and SPI-master signals of the frame scheduler, bundled with scheduler-side and
// environment-side views.
interface spi_frame_scheduler_if #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned MAX_BYTES = spi_sched_pkg::DEFAULT_MAX_BYTES
);
   import spi_sched_pkg::*;

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*LEN_W-1:0]       req_len;
   logic [NUM_REQ*8*MAX_BYTES-1:0] req_data;
   logic [NUM_REQ-1:0]             grant;
   logic [NUM_REQ-1:0]             done;
   logic                           busy;
   logic                           spi_transmit;
   logic [7:0]                     spi_data;
   logic                           spi_rearm;
   logic                           spi_finish;

   // Scheduler side.
   modport master (
      input  req, req_len, req_data, spi_finish,
      output grant, done, busy, spi_transmit, spi_data, spi_rearm
   );

   // Requesters plus the SPI master.
   modport slave (
      output req, req_len, req_data, spi_finish,
      input  grant, done, busy, spi_transmit, spi_data, spi_rearm
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the pointer wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] grant
);

   logic             found;
   logic [PTR_W-1:0] sel;

   // Walk the requesters starting at the pointer and wrap; grant the first one asserted.
   always_comb begin
      grant = '0;
      found = 1'b0;
      sel   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         sel = PTR_W'((32'(pointer) + k) % NUM_REQ);
         if (!found && req[sel]) begin
            grant[sel] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Shares one byte-wide SPI master between NUM_REQ requesters, sending each granted request as a
// multi-byte frame (highest byte first) with select held across the whole frame.
module spi_frame_scheduler #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned MAX_BYTES  = spi_sched_pkg::DEFAULT_MAX_BYTES,
   parameter int unsigned GAP_CYCLES = 3
) (
   input logic                   mainclk,
   input logic                   reset,
   spi_frame_scheduler_if.master bus
);
   import spi_sched_pkg::*;

   localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned FRAME_W = 8 * MAX_BYTES;

   sched_state_e       state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] done_q;
   logic               busy_q;
   logic               transmit_q;
   logic               rearm_q;
   logic [7:0]         data_q;
   logic               skip_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   owner_q;
   logic [IDX_W-1:0]   idx_q;
   logic [FRAME_W-1:0] shadow_q;
   logic [GAP_W-1:0]   gap_q;

   logic [NUM_REQ-1:0] arb_grant;
   logic [PTR_W-1:0]   win_idx;
   logic [IDX_W-1:0]   win_len;
   logic [FRAME_W-1:0] win_data;
   logic [7:0]         cur_byte;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .req    (bus.req),
      .pointer(ptr_q),
      .grant  (arb_grant)
   );

   // Encode the one-hot arbiter result so the winner's length and frame can be selected.
   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            win_idx = PTR_W'(i);
         end
      end
   end

   assign win_len  = sat_len(bus.req_len[LEN_W*win_idx +: LEN_W], MAX_BYTES);
   assign win_data = bus.req_data[FRAME_W*win_idx +: FRAME_W];
   assign cur_byte = shadow_q[8*idx_q +: 8];

   // Frame sequencer; every output is a register updated by the action of the current state.
   always_ff @(posedge mainclk) begin
      if (!reset) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         transmit_q <= 1'b0;
         rearm_q    <= 1'b1;
         data_q     <= '0;
         skip_q     <= 1'b0;
         ptr_q      <= '0;
         owner_q    <= '0;
         idx_q      <= '0;
         shadow_q   <= '0;
         gap_q      <= '0;
      end else begin
         done_q <= '0;
         unique case (state_q)
            StIdle: begin
               transmit_q <= 1'b0;
               rearm_q    <= 1'b1;
               if (|bus.req) begin
                  grant_q  <= arb_grant;
                  owner_q  <= win_idx;
                  shadow_q <= win_data;
                  idx_q    <= win_len;
                  busy_q   <= 1'b1;
                  state_q  <= StLoad;
               end
            end
            StLoad: begin
               data_q  <= cur_byte;
               rearm_q <= 1'b1;
               state_q <= StSend;
            end
            StSend: begin
               transmit_q <= 1'b1;
               rearm_q    <= 1'b0;
               skip_q     <= 1'b0;
               // The master still shows the previous byte's finish right after a rearm.
               if (bus.spi_finish && !skip_q) begin
                  if (idx_q != '0) begin
                     idx_q   <= idx_q - 1'b1;
                     state_q <= StRearm;
                  end else begin
                     state_q <= StDone;
                  end
               end
            end
            StRearm: begin
               // Transmit stays high so select is not released between bytes.
               transmit_q <= 1'b1;
               rearm_q    <= 1'b1;
               data_q     <= cur_byte;
               skip_q     <= 1'b1;
               state_q    <= StSend;
            end
            StDone: begin
               transmit_q <= 1'b0;
               rearm_q    <= 1'b1;
               done_q     <= grant_q;
               grant_q    <= '0;
               ptr_q      <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
               gap_q      <= '0;
               state_q    <= StGap;
            end
            StGap: begin
               if (gap_q == GAP_W'(GAP_CYCLES)) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant        = grant_q;
   assign bus.done         = done_q;
   assign bus.busy         = busy_q;
   assign bus.spi_transmit = transmit_q;
   assign bus.spi_data     = data_q;
   assign bus.spi_rearm    = rearm_q;

endmodule
